memory_access_controller: RTL
=============================

// Module: memory_access_controller
// PURPOSE
//  CPU-side initiator for the single-port byte memory interface (ctrl/addr/write/read buses).
//  Accepts byte or 16-bit word load/store requests over a valid/ready handshake.
//  Sequences them into single-byte memory cycles, honouring the memory's one-cycle registered-address read latency.
//  Returns read data and a completion pulse to the sequencer.
// PARAMETERS
//  DATA_W     8          memory byte width (matches DEFAULT_TYPE)
//  ADDR_W     8          memory address width (matches DEFAULT_TYPE)
//  MEM_DEPTH  `MEMSIZE   number of implemented memory bytes (used only by range check)
// PORTS
//  CLOCK      in   1         sole clock, all state on posedge
//  RESET_N    in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         controller idle; request accepted on posedge when req_valid&&req_ready
//  req_write  in   1         1=store, 0=load
//  req_word   in   1         1=16-bit little-endian access (A, A+1), 0=byte at A
//  req_addr   in   ADDR_W    start address A
//  req_wdata  in   2*DATA_W  store data; [15:8] ignored for byte stores
//  rsp_valid  out  1         one-cycle completion pulse (loads and stores); no backpressure
//  rsp_rdata  out  2*DATA_W  load data, valid while rsp_valid; [15:8]=0 for byte loads
//  rsp_err    out  1         range error, valid with rsp_valid (0 when macro off)
//  mem_ctrl   out  MEMORY_FLAG_TYPE  MEMORY_WRITE only during a store byte cycle, else MEMORY_IDLE
//  mem_addr   out  ADDR_W    memory address bus
//  mem_wdata  out  DATA_W    memory write bus
//  mem_rdata  in   DATA_W    memory read bus: mem[addr latched on previous edge]
// BEHAVIOUR
//  - All outputs registered. Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    mem_ctrl=MEMORY_IDLE, mem_addr=0, mem_wdata=0, state=IDLE.
//  - Request fields are captured at the accept edge; later changes on req_* have no effect.
//  - States: IDLE, RD_LO, RD_HI, RD_LAST, WR_HI, RSP. req_ready=1 only in IDLE.
//  - Byte load: accept edge E0 drives mem_addr=A -> RD_LO.
//    E1: memory latches A -> RD_LAST. E2: capture mem_rdata into rdata[7:0] -> RSP.
//    rsp_valid high in cycle after E2; latency 3 cycles from accept edge.
//  - Word load: E0 drives A -> RD_LO. E1 drives A+1 -> RD_HI.
//    E2 captures lo -> RD_LAST. E3 captures hi -> RSP; latency 4 cycles.
//  - Byte store: E0 drives MEMORY_WRITE, A, wdata[7:0]; memory writes at E1.
//    E1 sets mem_ctrl=MEMORY_IDLE and enters RSP.
//  - Word store: E0 drives lo at A -> WR_HI. E1 drives hi at A+1. E2 sets IDLE -> RSP.
//    MEMORY_WRITE is asserted for exactly 1 or 2 consecutive cycles.
//  - RSP: rsp_valid=1 for one cycle, then IDLE; rsp_rdata holds value until next load completes.
//  - A+1 computed mod 2^ADDR_W: word at 0xFF uses 0xFF then 0x00.
//  - req_valid while busy is ignored (not queued); requester holds it until req_ready.
//  - RESET_N low mid-operation: outputs return to reset values immediately.
//    A pending write whose edge has not occurred is not performed, and no rsp_valid is issued.
// CONFIGURATION
//  MEMACC_RANGE_CHECK_EN defined: at accept, A>=MEM_DEPTH or (word and A+1>=MEM_DEPTH, wrap included)
//    -> no memory cycle issued (mem_ctrl stays MEMORY_IDLE).
//    Next state RSP: rsp_valid=1 with rsp_err=1, rsp_rdata=0.
//  MEMACC_RANGE_CHECK_EN undefined: rsp_err tied 0; addresses passed through unchecked.
// STRUCTURE
//  typedef_collection.sv: DEFAULT_TYPE, MEMORY_FLAG_TYPE (MEMORY_IDLE, MEMORY_WRITE),
//    new WORD_TYPE (2*DATA_W), new MEMACC_STATE_TYPE enum.
//  Single module, no sub-modules; the bench instantiates it with memory_unit.
// TESTING
//  - Byte load A=0x10, mem[0x10]=0x5A -> rsp_valid 3 cycles after accept, rsp_rdata=0x005A, rsp_err=0.
//  - Word store A=0x20, wdata=0xBEEF -> MEMORY_WRITE exactly 2 cycles;
//    mem[0x20]=0xEF, mem[0x21]=0xBE; word load A=0x20 returns 0xBEEF after 4 cycles.
//  - Word load A=0xFF with mem[0xFF]=0x11, mem[0x00]=0x22 -> rsp_rdata=0x2211 (macro off).
//  - Back-to-back: req_valid held high with 2nd request -> 2nd accepted only in IDLE;
//    req_ready low throughout the 1st; both responses correct, in order.
//  - RESET_N pulsed low during word store, after the lo edge and before the hi edge
//    -> mem[A] written, mem[A+1] unchanged; outputs at reset values; no rsp_valid.
//  - MEMACC_RANGE_CHECK_EN, MEM_DEPTH=128: word load A=0x7F -> no MEMORY_WRITE, no addr change,
//    rsp_valid with rsp_err=1, rsp_rdata=0 one cycle after accept.

Source files
------------

// File: rtl/memory_access_controller_pkg.sv
// Shared types for the byte-memory access controller and its memory interface.
// MEMSIZE sets the implemented memory depth used by the optional range check.
`ifndef MEMSIZE
`define MEMSIZE 256
`endif

package memory_access_controller_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0]   DEFAULT_TYPE;
    typedef logic [2*BYTE_W-1:0] WORD_TYPE;

    typedef enum logic {
        MEMORY_IDLE  = 1'b0,
        MEMORY_WRITE = 1'b1
    } MEMORY_FLAG_TYPE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LO   = 3'd1,
        RD_HI   = 3'd2,
        RD_LAST = 3'd3,
        WR_HI   = 3'd4,
        RSP     = 3'd5
    } MEMACC_STATE_TYPE;

endpackage

// File: rtl/memory_access_controller.sv
// Sequences byte/word load-store requests into single-byte memory cycles.
// Optional feature macro: MEMACC_RANGE_CHECK_EN (reject out-of-range addresses with rsp_err).
module memory_access_controller
    import memory_access_controller_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = `MEMSIZE
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_word,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output MEMORY_FLAG_TYPE     mem_ctrl,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output MEMACC_STATE_TYPE    state
);

`ifdef MEMACC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // Handshake: a request is taken on the rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse with no backpressure.

    MEMACC_STATE_TYPE      state_d;
    logic                  ready_d;
    MEMORY_FLAG_TYPE       mem_ctrl_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [DATA_W-1:0]     wdata_d;
    logic                  rsp_valid_d;
    logic [2*DATA_W-1:0]   rdata_d;
    logic                  err_d;
    logic                  word_q, word_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [ADDR_W-1:0]     req_addr_p1;
    logic                  range_bad;

    // The second byte address wraps within the address space before comparison.
    assign req_addr_p1 = req_addr + 1'b1;
    assign range_bad   = RANGE_EN &&
                         ((32'(req_addr) >= MEM_DEPTH) ||
                          (req_word && (32'(req_addr_p1) >= MEM_DEPTH)));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_ctrl  <= MEMORY_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            word_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state     <= state_d;
            req_ready <= ready_d;
            mem_ctrl  <= mem_ctrl_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            word_q    <= word_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d     = state;
        ready_d     = 1'b0;
        mem_ctrl_d  = mem_ctrl;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata;
        err_d       = rsp_err;
        word_d      = word_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    ready_d = 1'b0;
                    word_d  = req_word;
                    hi_d    = req_wdata[2*DATA_W-1:DATA_W];
                    err_d   = 1'b0;
                    if (range_bad) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = '0;
                    end else if (req_write) begin
                        addr_d     = req_addr;
                        mem_ctrl_d = MEMORY_WRITE;
                        wdata_d    = req_wdata[DATA_W-1:0];
                        state_d    = WR_HI;
                    end else begin
                        addr_d  = req_addr;
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                if (word_q) begin
                    addr_d  = mem_addr + 1'b1;
                    state_d = RD_HI;
                end else begin
                    state_d = RD_LAST;
                end
            end
            RD_HI: begin
                lo_d    = mem_rdata;
                state_d = RD_LAST;
            end
            RD_LAST: begin
                rdata_d     = word_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            // word_q doubles as "high byte still to write" so one state covers both store sizes.
            WR_HI: begin
                if (word_q) begin
                    addr_d  = mem_addr + 1'b1;
                    wdata_d = hi_q;
                    word_d  = 1'b0;
                end else begin
                    mem_ctrl_d  = MEMORY_IDLE;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d    = 1'b1;
                mem_ctrl_d = MEMORY_IDLE;
                state_d    = IDLE;
            end
        endcase
    end

endmodule
